// File: rtl/pdm_deserializer.sv
// PDM microphone front end: divides the system clock into the mic bit clock,
// samples data_in on each rising bit-clock edge and emits packed words.
module pdm_deserializer #(
  parameter int CLK_DIV_HALF = 25,
  parameter int WORD_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  data_in,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  pdm_clk_o,
  output logic                  pdm_irsel_o
);

  localparam int DW = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [WORD_WIDTH-1:0] shift;
  logic                  word_ready;
  logic                  div_wrap;
  logic                  pdm_rise;

  // The divider only runs once RUN is registered, so the first bit-clock
  // rise lands a full half period after enable is first seen high.
  always_comb begin
    div_wrap = (state == ST_RUN) && (div_cnt == DIV_LAST);
    pdm_rise = div_wrap && !pdm_clk_o;
  end

  assign pdm_irsel_o = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      word_ready <= 1'b0;
      pdm_clk_o  <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
    end else if (!enable) begin
      // Idle discards any partial word and any strobe about to be issued.
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      word_ready <= 1'b0;
      pdm_clk_o  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= ST_RUN;
      done       <= word_ready;
      word_ready <= 1'b0;
      if (word_ready) begin
        data <= shift;
      end
      if (state == ST_RUN) begin
        if (div_wrap) begin
          div_cnt   <= '0;
          pdm_clk_o <= ~pdm_clk_o;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (pdm_rise) begin
        shift <= {shift[WORD_WIDTH-2:0], data_in};
        if (bit_cnt == BIT_LAST) begin
          bit_cnt    <= '0;
          word_ready <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_deserializer.sv
// Bench for pdm_deserializer: bit-level stimulus scheduled from the nominal
// bit-clock timeline, expected words and strobe cycles kept in queues.
module tb_pdm_deserializer;

  localparam int HALF   = 25;
  localparam int WW     = 16;
  localparam int PERIOD = 2 * HALF;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          data_in = 1'b0;
  logic          done;
  logic [WW-1:0] data;
  logic          pdm_clk_o;
  logic          pdm_irsel_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [WW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic          stim_bits[$];
  logic [WW-1:0] last_word = '0;

  logic          prev_done = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic          rst_evt   = 1'b0;

  pdm_deserializer #(.CLK_DIV_HALF(HALF), .WORD_WIDTH(WW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .data_in     (data_in),
    .done        (done),
    .data        (data),
    .pdm_clk_o   (pdm_clk_o),
    .pdm_irsel_o (pdm_irsel_o)
  );

  // Clock / cycle counter: after posedge n, cyc reads n.
  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_word(input logic [WW-1:0] v);
    for (int i = WW - 1; i >= 0; i--) stim_bits.push_back(v[i]);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) stim_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  // Driver: enable is raised at cycle p, so it is first seen at edge p+1,
  // sample k is taken at edge p+1+HALF+PERIOD*k and each completed word
  // strobes one edge later. Bits change half a bit period before sampling.
  task automatic feed(input int nbits, input bit suppress);
    int            p;
    int            last_edge;
    logic [WW-1:0] w;
    p      = cyc;
    enable = 1'b1;
    w      = '0;
    for (int k = 0; k < nbits; k++) begin
      wait_cyc(p + 1 + PERIOD * k);
      data_in = stim_bits[k];
      w = {w[WW-2:0], stim_bits[k]};
      if ((k % WW == WW - 1) && !(suppress && k == nbits - 1)) begin
        exp_q.push_back(w);
        exp_cyc_q.push_back(p + 1 + HALF + PERIOD * k + 1);
        last_word = w;
      end
    end
    last_edge = p + 1 + HALF + PERIOD * (nbits - 1);
    if (suppress) begin
      wait_cyc(last_edge);
      enable = 1'b0;
    end
    wait_cyc(last_edge + 2);
  endtask

  task automatic stop();
    enable = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wait_pdm(input logic lvl, output int at);
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if (pdm_clk_o === lvl) break;
      tick();
    end
    at = cyc;
  endtask

  // Monitor / scoreboard
  always @(negedge reset_n) rst_evt = 1'b1;

  always @(negedge clock) begin
    logic [WW-1:0] w;
    int            t;
    if (reset_n) begin
      if (done) begin
        check("done_width", prev_done, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: data=0x%0h with no word pending (cycle %0d)", data, cyc);
        end else begin
          w = exp_q.pop_front();
          t = exp_cyc_q.pop_front();
          check("word", data, w);
          check("done_cycle", cyc, t);
          check("irsel_run", pdm_irsel_o, 1'b0);
        end
      end
      if (data !== prev_data) begin
        if (rst_evt) check("data_reset", data, '0);
        else check("data_changes_with_done", done, 1'b1);
      end
    end
    prev_done = done;
    prev_data = data;
    rst_evt   = 1'b0;
  end

  initial begin
    int p;
    int t_rise;
    int t_fall;
    int t_rise2;

    // 1. Reset held with enable high and data toggling.
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      data_in = 1'($urandom_range(0, 1));
      if (i % 8 == 7) begin
        check("rst_pdm_clk", pdm_clk_o, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", data, '0);
        check("rst_irsel", pdm_irsel_o, 1'b0);
      end
    end
    enable  = 1'b0;
    reset_n = 1'b1;
    repeat (5) tick();

    // 2. Bit-clock timing.
    p = cyc;
    enable = 1'b1;
    wait_pdm(1'b1, t_rise);
    check("first_rise", t_rise, p + 1 + HALF);
    wait_pdm(1'b0, t_fall);
    check("high_width", t_fall - t_rise, HALF);
    wait_pdm(1'b1, t_rise2);
    check("period", t_rise2 - t_rise, PERIOD);
    check("irsel_clk", pdm_irsel_o, 1'b0);
    enable = 1'b0;
    tick();
    check("clk_low_on_disable", pdm_clk_o, 1'b0);
    repeat (5) tick();

    // 3. All-ones stream, three consecutive words.
    stim_bits.delete();
    push_word(16'hFFFF);
    push_word(16'hFFFF);
    push_word(16'hFFFF);
    feed(3 * WW, 1'b0);
    stop();

    // 4. Fixed pattern followed by random words.
    stim_bits.delete();
    push_word(16'hA5C3);
    push_random(3 * WW);
    feed(4 * WW, 1'b0);
    stop();

    // 5. Enable drop after a partial word, then a fresh all-ones word.
    stim_bits.delete();
    push_random(7);
    feed(7, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 25 == 24) check("idle_pdm_clk", pdm_clk_o, 1'b0);
    end
    check("idle_data_held", data, last_word);
    stim_bits.delete();
    push_word(16'hFFFF);
    feed(WW, 1'b0);
    stop();

    // Strobe suppressed when enable drops on the word-load edge.
    stim_bits.delete();
    push_random(WW);
    feed(WW, 1'b1);
    repeat (10) tick();
    check("suppressed_data_kept", data, 16'hFFFF);
    check("suppressed_done_low", done, 1'b0);
    repeat (5) tick();

    // 6. Asynchronous reset mid-word, then a full new word.
    stim_bits.delete();
    push_random(10);
    feed(10, 1'b0);
    #4;
    reset_n = 1'b0;
    #2;
    check("async_rst_data", data, '0);
    check("async_rst_pdm_clk", pdm_clk_o, 1'b0);
    check("async_rst_done", done, 1'b0);
    #1;
    reset_n = 1'b1;
    stim_bits.delete();
    push_random(WW);
    feed(WW, 1'b0);
    stop();

    repeat (10) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
